// File: rtl/automata_stream_sched_if.sv
// Bundle of trace-source, automata-engine and result-record signals around the stream scheduler.
// The master modport is the scheduler; the slave modport is the surrounding sources/engine/consumer.
interface automata_stream_sched_if #(
  parameter int N_SRC = 4,
  parameter int SYM_W = 8,
  parameter int N_RPT = 4,
  parameter int CNT_W = 16
);
  localparam int IDX_W = $clog2(N_SRC);

  logic [N_SRC-1:0]       src_valid;
  logic [N_SRC-1:0]       src_last;
  logic [N_SRC*SYM_W-1:0] src_data;
  logic [N_SRC-1:0]       src_ready;

  logic                   ae_reset;
  logic                   ae_run;
  logic [SYM_W-1:0]       ae_symbols;
  logic [N_RPT-1:0]       ae_report;

  logic                   res_valid;
  logic                   res_ready;
  logic [IDX_W-1:0]       res_src;
  logic [N_RPT-1:0]       res_report;
  logic [CNT_W-1:0]       res_len;

  modport master (
    input  src_valid, src_last, src_data, ae_report, res_ready,
    output src_ready, ae_reset, ae_run, ae_symbols, res_valid, res_src, res_report, res_len
  );

  modport slave (
    output src_valid, src_last, src_data, ae_report, res_ready,
    input  src_ready, ae_reset, ae_run, ae_symbols, res_valid, res_src, res_report, res_len
  );
endinterface

// File: rtl/automata_stream_sched.sv
// Time-shares one automata engine between N_SRC trace sources, one whole trace at a time,
// round-robin, returning a (source, OR'd report, length) record per trace.
module automata_stream_sched #(
  parameter int N_SRC   = 4,
  parameter int SYM_W   = 8,
  parameter int N_RPT   = 4,
  parameter int RPT_LAT = 1,
  parameter int CNT_W   = 16
) (
  input logic                     clk,
  input logic                     reset,
  automata_stream_sched_if.master bus
);
  localparam int IDX_W = $clog2(N_SRC);

  typedef enum logic [2:0] {IDLE, CLR, STREAM, DRAIN, RESULT} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] grant, rr_ptr, pick, rr_next;
  logic             pick_found;
  logic [N_RPT-1:0] acc;
  logic [CNT_W-1:0] len;
  logic [2:0]       drain_cnt;
  logic             started;
  logic             accept;
  logic [SYM_W-1:0] src_sym [N_SRC];

  for (genvar g = 0; g < N_SRC; g++) begin : g_sym
    assign src_sym[g] = bus.src_data[g*SYM_W +: SYM_W];
  end

  // First valid source at or after the rr pointer, wrapping around.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    pick       = '0;
    pick_found = 1'b0;
    sum        = '0;
    cand       = '0;
    for (int k = 0; k < N_SRC; k++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_SRC)) sum = sum - (IDX_W+1)'(N_SRC);
      cand = sum[IDX_W-1:0];
      if (!pick_found && bus.src_valid[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  assign accept  = (state == STREAM) && !reset && bus.src_valid[grant];
  assign rr_next = (grant == IDX_W'(N_SRC-1)) ? '0 : grant + 1'b1;

  assign bus.res_src    = grant;
  assign bus.res_report = acc;
  assign bus.res_len    = len;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Outputs are forced quiet while reset is high so a half-streamed trace is not advanced.
  always_comb begin
    state_nxt      = state;
    bus.src_ready  = '0;
    bus.ae_run     = 1'b0;
    bus.ae_symbols = '0;
    bus.ae_reset   = reset;
    bus.res_valid  = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:   if (pick_found) state_nxt = CLR;
        CLR: begin
          bus.ae_reset = 1'b1;
          state_nxt    = STREAM;
        end
        STREAM: begin
          bus.src_ready[grant] = 1'b1;
          bus.ae_run           = bus.src_valid[grant];
          bus.ae_symbols       = src_sym[grant];
          if (accept && bus.src_last[grant]) state_nxt = DRAIN;
        end
        DRAIN:  if (drain_cnt == 3'd0) state_nxt = RESULT;
        RESULT: begin
          bus.res_valid = 1'b1;
          if (bus.res_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Reports lag symbols by RPT_LAT, so sampling starts the cycle after the first accept and
  // continues through DRAIN; nothing is sampled once RESULT is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant     <= '0;
      rr_ptr    <= '0;
      acc       <= '0;
      len       <= '0;
      drain_cnt <= '0;
      started   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant   <= pick;
            acc     <= '0;
            len     <= '0;
            started <= 1'b0;
          end
        end
        STREAM: begin
          if (started) acc <= acc | bus.ae_report;
          if (accept) begin
            started <= 1'b1;
            if (len != {CNT_W{1'b1}}) len <= len + 1'b1;
            if (bus.src_last[grant]) drain_cnt <= 3'(RPT_LAT-1);
          end
        end
        DRAIN: begin
          acc <= acc | bus.ae_report;
          if (drain_cnt != 3'd0) drain_cnt <= drain_cnt - 3'd1;
        end
        RESULT: begin
          if (bus.res_ready) rr_ptr <= rr_next;
        end
        default: ;
      endcase
    end
  end
endmodule
